// File: rtl/param_register_file_if.sv
// Register file bus: write port, reserve port, two read ports and their registered results.
// The master drives requests; the slave (the register file) returns data, busy flags and count.
interface param_register_file_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  controlRegWrite;
    logic [ADDR_WIDTH-1:0] writeReg;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  controlRegReserve;
    logic [ADDR_WIDTH-1:0] reserveReg;
    logic [ADDR_WIDTH-1:0] readReg1;
    logic [ADDR_WIDTH-1:0] readReg2;
    logic [DATA_WIDTH-1:0] reg1Data;
    logic [DATA_WIDTH-1:0] reg2Data;
    logic                  reg1Busy;
    logic                  reg2Busy;
    logic [ADDR_WIDTH:0]   busyCount;

    modport master (
        output controlRegWrite,
        output writeReg,
        output writeData,
        output controlRegReserve,
        output reserveReg,
        output readReg1,
        output readReg2,
        input  reg1Data,
        input  reg2Data,
        input  reg1Busy,
        input  reg2Busy,
        input  busyCount
    );

    modport slave (
        input  controlRegWrite,
        input  writeReg,
        input  writeData,
        input  controlRegReserve,
        input  reserveReg,
        input  readReg1,
        input  readReg2,
        output reg1Data,
        output reg2Data,
        output reg1Busy,
        output reg2Busy,
        output busyCount
    );
endinterface

// File: rtl/param_register_file.sv
// Two-read, one-write register file with a pending (scoreboard) bit per register.
// All state and outputs update on the falling edge of clock; reads see same-edge writes.
module param_register_file #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned ZERO_REG   = 0
) (
    input logic                  clock,
    input logic                  reset,
    param_register_file_if.slave bus
);
    localparam int unsigned Depth   = 2 ** ADDR_WIDTH;
    localparam int unsigned CntW    = ADDR_WIDTH + 1;
    localparam bit          ZeroReg = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [Depth-1:0]      pending_q, pending_d;

    logic [DATA_WIDTH-1:0] reg1_data_q, reg1_data_d;
    logic [DATA_WIDTH-1:0] reg2_data_q, reg2_data_d;
    logic                  reg1_busy_q, reg1_busy_d;
    logic                  reg2_busy_q, reg2_busy_d;
    logic [CntW-1:0]       busy_count_q, busy_count_d;

    logic write_en;
    logic reserve_en;
    logic zero1, zero2;

    function automatic logic is_zero_idx(input logic [ADDR_WIDTH-1:0] idx);
        return ZeroReg && (idx == '0);
    endfunction

    always_comb begin
        write_en   = bus.controlRegWrite && !is_zero_idx(bus.writeReg);
        reserve_en = bus.controlRegReserve && !is_zero_idx(bus.reserveReg);
        zero1      = is_zero_idx(bus.readReg1);
        zero2      = is_zero_idx(bus.readReg2);
    end

    // Reserve is applied after the write clear so a same-index reserve wins.
    always_comb begin
        pending_d = pending_q;
        if (write_en) begin
            pending_d[bus.writeReg] = 1'b0;
        end
        if (reserve_en) begin
            pending_d[bus.reserveReg] = 1'b1;
        end
    end

    always_comb begin
        busy_count_d = '0;
        for (int i = 0; i < Depth; i++) begin
            busy_count_d = busy_count_d + {{ADDR_WIDTH{1'b0}}, pending_d[i]};
        end
    end

    always_comb begin
        reg1_data_d = mem_q[bus.readReg1];
        if (zero1) begin
            reg1_data_d = '0;
        end else if (write_en && (bus.writeReg == bus.readReg1)) begin
            reg1_data_d = bus.writeData;
        end

        reg2_data_d = mem_q[bus.readReg2];
        if (zero2) begin
            reg2_data_d = '0;
        end else if (write_en && (bus.writeReg == bus.readReg2)) begin
            reg2_data_d = bus.writeData;
        end

        reg1_busy_d = !zero1 && pending_d[bus.readReg1];
        reg2_busy_d = !zero2 && pending_d[bus.readReg2];
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            pending_q    <= '0;
            reg1_data_q  <= '0;
            reg2_data_q  <= '0;
            reg1_busy_q  <= 1'b0;
            reg2_busy_q  <= 1'b0;
            busy_count_q <= '0;
        end else begin
            if (write_en) begin
                mem_q[bus.writeReg] <= bus.writeData;
            end
            pending_q    <= pending_d;
            reg1_data_q  <= reg1_data_d;
            reg2_data_q  <= reg2_data_d;
            reg1_busy_q  <= reg1_busy_d;
            reg2_busy_q  <= reg2_busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign bus.reg1Data  = reg1_data_q;
    assign bus.reg2Data  = reg2_data_q;
    assign bus.reg1Busy  = reg1_busy_q;
    assign bus.reg2Busy  = reg2_busy_q;
    assign bus.busyCount = busy_count_q;
endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: two instances (ZERO_REG=0 and ZERO_REG=1) share one stimulus
// stream and are checked every cycle against an array model plus literal spot checks.
module tb_param_register_file;
    logic        clock = 1'b0;
    logic        reset;
    logic        we, rs;
    logic [3:0]  wr, rr, r1, r2;
    logic [15:0] wd;
    bit          check_en = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    param_register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus0 ();
    param_register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus1 ();

    assign bus0.controlRegWrite   = we;
    assign bus0.writeReg          = wr;
    assign bus0.writeData         = wd;
    assign bus0.controlRegReserve = rs;
    assign bus0.reserveReg        = rr;
    assign bus0.readReg1          = r1;
    assign bus0.readReg2          = r2;
    assign bus1.controlRegWrite   = we;
    assign bus1.writeReg          = wr;
    assign bus1.writeData         = wd;
    assign bus1.controlRegReserve = rs;
    assign bus1.reserveReg        = rr;
    assign bus1.readReg1          = r1;
    assign bus1.readReg2          = r2;

    param_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ZERO_REG(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    param_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ZERO_REG(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: m=0 plain, m=1 with register 0 hardwired to zero.
    logic [15:0] mmem  [2][16];
    bit          mpend [2][16];
    logic [15:0] exp_d1 [2], exp_d2 [2];
    logic        exp_b1 [2], exp_b2 [2];
    logic [4:0]  exp_cnt [2];

    always @(negedge clock) begin
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                for (int i = 0; i < 16; i++) begin
                    mmem[m][i]  = 16'h0;
                    mpend[m][i] = 1'b0;
                end
                exp_d1[m] = 16'h0; exp_d2[m] = 16'h0;
                exp_b1[m] = 1'b0;  exp_b2[m] = 1'b0;
                exp_cnt[m] = 5'd0;
            end else begin
                bit zr;
                int n;
                zr = (m == 1);
                if (we && !(zr && wr == 4'd0)) begin
                    mmem[m][wr]  = wd;
                    mpend[m][wr] = 1'b0;
                end
                if (rs && !(zr && rr == 4'd0)) mpend[m][rr] = 1'b1;
                // Reading the already-updated array gives the same-edge bypass.
                exp_d1[m] = mmem[m][r1];
                exp_d2[m] = mmem[m][r2];
                exp_b1[m] = mpend[m][r1];
                exp_b2[m] = mpend[m][r2];
                n = 0;
                for (int i = 0; i < 16; i++) n += int'(mpend[m][i]);
                exp_cnt[m] = 5'(n);
            end
        end
    end

    always @(posedge clock) begin
        if (check_en) begin
            chk("d0.reg1Data",  {16'h0, bus0.reg1Data},  {16'h0, exp_d1[0]});
            chk("d0.reg2Data",  {16'h0, bus0.reg2Data},  {16'h0, exp_d2[0]});
            chk("d0.reg1Busy",  {31'h0, bus0.reg1Busy},  {31'h0, exp_b1[0]});
            chk("d0.reg2Busy",  {31'h0, bus0.reg2Busy},  {31'h0, exp_b2[0]});
            chk("d0.busyCount", {27'h0, bus0.busyCount}, {27'h0, exp_cnt[0]});
            chk("d1.reg1Data",  {16'h0, bus1.reg1Data},  {16'h0, exp_d1[1]});
            chk("d1.reg2Data",  {16'h0, bus1.reg2Data},  {16'h0, exp_d2[1]});
            chk("d1.reg1Busy",  {31'h0, bus1.reg1Busy},  {31'h0, exp_b1[1]});
            chk("d1.reg2Busy",  {31'h0, bus1.reg2Busy},  {31'h0, exp_b2[1]});
            chk("d1.busyCount", {27'h0, bus1.busyCount}, {27'h0, exp_cnt[1]});
        end
    end

    task automatic tick();
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wr = 4'd0; wd = 16'h0;
        rs = 1'b0; rr = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        r1 = 4'd0; r2 = 4'd0;
        tick();
        check_en = 1'b1;
        tick();
        chk("reset.reg1Data",  {16'h0, bus0.reg1Data}, 32'h0);
        chk("reset.busyCount", {27'h0, bus0.busyCount}, 32'h0);

        // Write and reserve r0 on both instances.
        reset = 1'b0;
        we = 1'b1; wr = 4'd0; wd = 16'hFFFF; rs = 1'b1; rr = 4'd0;
        tick();
        chk("zr.d1.reg1Data",  {16'h0, bus1.reg1Data}, 32'h0);
        chk("zr.d1.reg2Busy",  {31'h0, bus1.reg2Busy}, 32'h0);
        chk("zr.d1.busyCount", {27'h0, bus1.busyCount}, 32'h0);
        chk("zr.d0.reg1Data",  {16'h0, bus0.reg1Data}, 32'hFFFF);
        chk("zr.d0.busyCount", {27'h0, bus0.busyCount}, 32'h1);
        wd = 16'h0; rs = 1'b0;
        tick();
        chk("zr.d0.clear", {27'h0, bus0.busyCount}, 32'h0);

        we = 1'b1; wr = 4'd5; wd = 16'hBEEF;
        tick();
        idle(); r1 = 4'd5;
        tick();
        chk("beef.reg1Data", {16'h0, bus0.reg1Data}, 32'hBEEF);
        chk("beef.reg1Busy", {31'h0, bus0.reg1Busy}, 32'h0);

        we = 1'b1; wr = 4'd3; wd = 16'h1234; r1 = 4'd3; r2 = 4'd3;
        tick();
        chk("bypass.reg1Data", {16'h0, bus0.reg1Data}, 32'h1234);
        chk("bypass.reg2Data", {16'h0, bus0.reg2Data}, 32'h1234);

        idle(); rs = 1'b1; rr = 4'd7;
        tick();
        rr = 4'd9;
        tick();
        rr = 4'd7;
        tick();
        chk("resv.busyCount", {27'h0, bus0.busyCount}, 32'h2);
        idle(); we = 1'b1; wr = 4'd7; wd = 16'h0777; r1 = 4'd7;
        tick();
        chk("wr7.busyCount", {27'h0, bus0.busyCount}, 32'h1);
        chk("wr7.reg1Busy",  {31'h0, bus0.reg1Busy}, 32'h0);
        chk("wr7.reg1Data",  {16'h0, bus0.reg1Data}, 32'h0777);

        idle(); rs = 1'b1; rr = 4'd4;
        tick();
        we = 1'b1; wr = 4'd4; wd = 16'h4444; r1 = 4'd4;
        tick();
        chk("wrres.reg1Busy",  {31'h0, bus0.reg1Busy}, 32'h1);
        chk("wrres.busyCount", {27'h0, bus0.busyCount}, 32'h2);
        chk("wrres.reg1Data",  {16'h0, bus0.reg1Data}, 32'h4444);

        // Reset held while a write/reserve is requested: nothing takes effect.
        reset = 1'b1; we = 1'b1; wr = 4'd2; wd = 16'h2222; rs = 1'b1; rr = 4'd2; r1 = 4'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rsthold.busyCount", {27'h0, bus0.busyCount}, 32'h0);
            chk("rsthold.reg1Data",  {16'h0, bus0.reg1Data}, 32'h0);
        end
        reset = 1'b0; idle();
        tick();
        chk("afterrst.reg1Data", {16'h0, bus0.reg1Data}, 32'h0);
        chk("afterrst.reg1Busy", {31'h0, bus0.reg1Busy}, 32'h0);

        for (int k = 0; k < 60; k++) begin
            we = 1'($urandom); wr = 4'($urandom); wd = 16'($urandom);
            rs = 1'($urandom); rr = 4'($urandom);
            r1 = 4'($urandom); r2 = (k % 4 == 0) ? r1 : 4'($urandom);
            if (k % 5 == 0) r1 = wr;
            tick();
        end

        for (int i = 0; i < 16; i++) begin
            we = 1'b1; wr = 4'(i); wd = 16'hA000 | 16'(i);
            rs = 1'b1; rr = 4'(i); r1 = 4'(i); r2 = 4'(15 - i);
            tick();
        end
        chk("full.d0.busyCount", {27'h0, bus0.busyCount}, 32'h10);
        chk("full.d1.busyCount", {27'h0, bus1.busyCount}, 32'hF);

        reset = 1'b1; we = 1'b1; wr = 4'd1; wd = 16'hFFFF; rs = 1'b1; rr = 4'd1; r1 = 4'd1;
        tick();
        chk("fullrst.reg1Data",  {16'h0, bus0.reg1Data}, 32'h0);
        chk("fullrst.reg2Data",  {16'h0, bus0.reg2Data}, 32'h0);
        chk("fullrst.reg1Busy",  {31'h0, bus0.reg1Busy}, 32'h0);
        chk("fullrst.reg2Busy",  {31'h0, bus0.reg2Busy}, 32'h0);
        chk("fullrst.busyCount", {27'h0, bus0.busyCount}, 32'h0);
        reset = 1'b0; idle();
        for (int i = 0; i < 16; i++) begin
            r1 = 4'(i); r2 = 4'(i);
            tick();
            chk("clean.reg1Data", {16'h0, bus0.reg1Data}, 32'h0);
            chk("clean.reg2Data", {16'h0, bus0.reg2Data}, 32'h0);
        end

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
